sfx_sequencer: RTL and testbench
================================

Name: sfx_sequencer

Overview:
- Sound-effect scheduler for the Tetris audio path.
- Accepts one-cycle event pulses from game logic (lock, line clear, rotate, game over).
- Arbitrates among them by fixed priority and steps through a short per-effect table of tone/noise steps.
- Drives the SFX DDS channel (addition value, tone gate), the noise gate and a BGM duck flag into the sound generator. Runs alongside the BGM ROM controller on the 9 MHz system clock.

Parameters:
NUM_REQ, 4, number of request lines/effects; effect id = line index; higher index = higher priority
STEPS, 8, table slots per effect; effect k occupies table addresses k*STEPS .. k*STEPS+STEPS-1
DUR_W, 8, width of per-step duration field in ms
DUCK_EN, 1, when 1, o_bgm_duck follows o_busy; when 0, o_bgm_duck is tied to 0

Ports:
i_clk  in  1  system clock, 9 MHz
i_res_n  in  1  asynchronous active-low reset
i_tick_1ms  in  1  one-cycle enable every 1 ms (from the shared 1 ms prescaler)
i_req  in  NUM_REQ  one-cycle request pulses, one per effect
o_dds_add_val  out  16  DDS addition value for the SFX channel
o_tone_en  out  1  SFX tone channel unmuted
o_noise_en  out  1  LFSR noise gate
o_busy  out  1  an effect is playing
o_active_id  out  log2(NUM_REQ)  id of the playing effect
o_bgm_duck  out  1  request BGM attenuation while an SFX plays

Behaviour:
- Reset (i_res_n low, asynchronous): all outputs 0; pending register 0; state IDLE; step address 0; duration counter 0.
- Step word, 26 bits: [25] last, [24] noise, [23:16] dur_ms, [15:0] add_val. add_val 0 means tone silent: o_tone_en=0 for that step.
- Table is read via a synchronous ROM with 1-cycle latency.
- Pending register pend[NUM_REQ-1:0]:
  - i_req bits OR into pend each cycle.
  - A pend bit clears only in the cycle its effect is launched.
  - A request arriving in the same cycle as the clear of the same bit sets it again; set wins.
- Arbiter: selects the highest set bit of pend.
- State IDLE:
  - If pend != 0: launch the selected effect (clear its bit, addr = sel*STEPS, o_active_id = sel, o_busy = 1) and go to FETCH.
  - Otherwise all gate outputs stay 0.
- State FETCH, one cycle:
  - Latch ROM data into o_dds_add_val, o_tone_en (add_val != 0) and o_noise_en (noise bit).
  - Latch the last flag.
  - Load the duration counter with dur_ms; dur_ms = 0 is treated as 1.
  - Go to PLAY.
- State PLAY: on i_tick_1ms, decrement the counter. When it reaches 0:
  - If last=1, or this is step index STEPS-1 (implicit last; never wraps into the next effect): tone_en=0, noise_en=0 and busy=0 in the same cycle, go to IDLE. o_dds_add_val holds its value.
  - Else addr+1, go to FETCH.
- Latency: i_req at cycle t gives o_busy=1 at t+2 and the first-step outputs valid at t+3. The first step lasts dur_ms ticks, counted from the first i_tick_1ms after entering PLAY.
- Preemption: in FETCH or PLAY, if pend holds a bit with id >= o_active_id, launch it immediately (same actions as IDLE launch) and go to FETCH.
  - The same id re-requested restarts the effect.
  - Outputs keep their old values until the new FETCH.
  - Preemption takes precedence over step end in the same cycle.
- Lower-priority requests stay pending and play after the current effect ends. IDLE re-launches the next cycle; no gap tick is inserted.
- o_bgm_duck = DUCK_EN & o_busy, registered together with o_busy.
- i_tick_1ms has no effect in IDLE or FETCH.

Decomposition:
- Package sfx_pkg holds:
  - the step-word field positions (LAST_BIT, NOISE_BIT, DUR_MSB/LSB, ADD_MSB/LSB);
  - effect id constants (SFX_LOCK=0, SFX_ROTATE=1, SFX_LINE=2, SFX_OVER=3);
  - state encoding IDLE/FETCH/PLAY.
- One sub-module: sfx_rom (i_clk, i_res_n, i_addr[log2(NUM_REQ*STEPS)-1:0], o_data[25:0]), synchronous case-table ROM.
  - Bench content: effect 0 = {last, noise, dur 3, 16'h0000}.
  - Effect 2 = {dur 2, 16'h0F00}, {dur 2, 16'h1400}, {last, dur 4, 16'h1E00}.

Test Plan:
1. Reset mid-PLAY of effect 2 -> all outputs 0 immediately; after release, pend is clear and IDLE is held with no spurious playback.
2. i_req=4'b0001 at cycle t, i_tick_1ms every 20 cycles -> o_busy=1 at t+2; o_noise_en=1, o_tone_en=0 at t+3; both drop after exactly 3 ticks; o_busy=0 and o_bgm_duck=0 on that cycle.
3. i_req=4'b0100 -> o_dds_add_val 16'h0F00 for 2 ticks, then 16'h1400 for 2 ticks, then 16'h1E00 for 4 ticks, then o_tone_en=0 and IDLE.
4. Effect 0 playing, i_req=4'b0100 -> effect 2 preempts within 2 cycles, o_active_id=2; effect 0 does not resume.
5. Effect 2 playing, i_req=4'b0001 -> ignored until effect 2 ends; effect 0 starts on the next cycle, o_active_id=0.
6. i_req=4'b0101 in the same cycle -> effect 2 plays first, then effect 0. Repeated i_req[2] mid-play -> effect 2 restarts at 16'h0F00.

Source files
------------

// File: rtl/sfx_pkg.sv
// Shared definitions for the SFX sequencer: step-word layout, effect ids,
// FSM state encoding and a step-word builder used by the effect table.
package sfx_pkg;

  localparam int STEP_W    = 26;
  localparam int LAST_BIT  = 25;
  localparam int NOISE_BIT = 24;
  localparam int DUR_MSB   = 23;
  localparam int DUR_LSB   = 16;
  localparam int ADD_MSB   = 15;
  localparam int ADD_LSB   = 0;

  localparam int SFX_LOCK   = 0;
  localparam int SFX_ROTATE = 1;
  localparam int SFX_LINE   = 2;
  localparam int SFX_OVER   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } state_t;

  function automatic logic [STEP_W-1:0] mk_step(input logic       last,
                                                input logic       noise,
                                                input logic [7:0] dur,
                                                input logic [15:0] add);
    return {last, noise, dur, add};
  endfunction

endpackage

// File: rtl/sfx_rom.sv
// Effect step table, one registered read per cycle (1-cycle latency).
// Effect k lives at addresses k*8 .. k*8+7; unused slots read as zero.
module sfx_rom
  import sfx_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_res_n,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [STEP_W-1:0] o_data
);

  logic [STEP_W-1:0] word;

  always_comb begin
    word = '0;
    case (i_addr)
      ADDR_W'(0):  word = mk_step(1'b1, 1'b1, 8'd3, 16'h0000);
      ADDR_W'(8):  word = mk_step(1'b1, 1'b0, 8'd2, 16'h2000);
      ADDR_W'(16): word = mk_step(1'b0, 1'b0, 8'd2, 16'h0F00);
      ADDR_W'(17): word = mk_step(1'b0, 1'b0, 8'd2, 16'h1400);
      ADDR_W'(18): word = mk_step(1'b1, 1'b0, 8'd4, 16'h1E00);
      default: begin
        // Game-over sweep: eight 1 ms steps with no last flag, ends on slot 7.
        if (i_addr[ADDR_W-1:3] == (ADDR_W-3)'(SFX_OVER))
          word = mk_step(1'b0, 1'b0, 8'd1, {4'h0, 1'b1, i_addr[2:0], 8'h00});
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) o_data <= '0;
    else          o_data <= word;
  end

endmodule

// File: rtl/sfx_sequencer.sv
// Fixed-priority SFX scheduler: latches request pulses, launches the highest
// pending effect and walks its step table, driving the SFX DDS and gates.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int STEPS   = 8,
  parameter int DUR_W   = 8,
  parameter bit DUCK_EN = 1'b1,
  localparam int IDW    = $clog2(NUM_REQ),
  localparam int SW     = $clog2(STEPS),
  localparam int ADDR_W = $clog2(NUM_REQ * STEPS)
) (
  input  logic               i_clk,
  input  logic               i_res_n,
  input  logic               i_tick_1ms,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [15:0]        o_dds_add_val,
  output logic               o_tone_en,
  output logic               o_noise_en,
  output logic               o_busy,
  output logic [IDW-1:0]     o_active_id,
  output logic               o_bgm_duck,
  output state_t             o_dbg_state
);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d, pend_clr;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [15:0]        add_q, add_d;
  logic               tone_q, tone_d, noise_q, noise_d;
  logic               busy_q, busy_d, duck_q, duck_d;
  logic [IDW-1:0]     id_q, id_d, sel;
  logic               pend_any, launch;
  logic [STEP_W-1:0]  rom_data;
  logic [DUR_W-1:0]   rom_dur;

  // The ROM is addressed with the next address so FETCH sees its word.
  sfx_rom #(.ADDR_W(ADDR_W)) u_rom (
    .i_clk  (i_clk),
    .i_res_n(i_res_n),
    .i_addr (addr_d),
    .o_data (rom_data)
  );

  assign rom_dur  = DUR_W'(rom_data[DUR_MSB:DUR_LSB]);
  assign pend_any = |pend_q;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pend_q[i]) sel = IDW'(i);
  end

  always_comb begin
    state_d  = state_q;
    pend_clr = '0;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    add_d    = add_q;
    tone_d   = tone_q;
    noise_d  = noise_q;
    busy_d   = busy_q;
    id_d     = id_q;
    launch   = 1'b0;
    case (state_q)
      IDLE:        launch = pend_any;
      FETCH, PLAY: launch = pend_any && (sel >= id_q);
      default:     launch = 1'b0;
    endcase
    // Launch (fresh or preempting) wins over any step bookkeeping this cycle.
    if (launch) begin
      pend_clr[sel] = 1'b1;
      addr_d        = ADDR_W'(sel) << SW;
      id_d          = sel;
      busy_d        = 1'b1;
      state_d       = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          add_d   = rom_data[ADD_MSB:ADD_LSB];
          tone_d  = (rom_data[ADD_MSB:ADD_LSB] != 16'h0000);
          noise_d = rom_data[NOISE_BIT];
          last_d  = rom_data[LAST_BIT];
          cnt_d   = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
          state_d = PLAY;
        end
        PLAY: begin
          if (i_tick_1ms) begin
            cnt_d = cnt_q - DUR_W'(1);
            if (cnt_q == DUR_W'(1)) begin
              if (last_q || (addr_q[SW-1:0] == SW'(STEPS - 1))) begin
                tone_d  = 1'b0;
                noise_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
              end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = FETCH;
              end
            end
          end
        end
        default: ;
      endcase
    end
    pend_d = (pend_q & ~pend_clr) | i_req;
    duck_d = DUCK_EN & busy_d;
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      add_q   <= '0;
      tone_q  <= 1'b0;
      noise_q <= 1'b0;
      busy_q  <= 1'b0;
      duck_q  <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      add_q   <= add_d;
      tone_q  <= tone_d;
      noise_q <= noise_d;
      busy_q  <= busy_d;
      duck_q  <= duck_d;
      id_q    <= id_d;
    end
  end

  assign o_dds_add_val = add_q;
  assign o_tone_en     = tone_q;
  assign o_noise_en    = noise_q;
  assign o_busy        = busy_q;
  assign o_bgm_duck    = duck_q;
  assign o_active_id   = id_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer: latency, step timing, priority,
// preemption, restart, implicit last step and asynchronous reset.
module tb_sfx_sequencer;
  import sfx_pkg::*;

  logic        clk;
  logic        i_res_n;
  logic        i_tick_1ms;
  logic [3:0]  i_req;
  logic [15:0] o_dds_add_val;
  logic        o_tone_en, o_noise_en, o_busy, o_bgm_duck;
  logic [1:0]  o_active_id;
  state_t      o_dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_add;

  sfx_sequencer dut (
    .i_clk        (clk),
    .i_res_n      (i_res_n),
    .i_tick_1ms   (i_tick_1ms),
    .i_req        (i_req),
    .o_dds_add_val(o_dds_add_val),
    .o_tone_en    (o_tone_en),
    .o_noise_en   (o_noise_en),
    .o_busy       (o_busy),
    .o_active_id  (o_active_id),
    .o_bgm_duck   (o_bgm_duck),
    .o_dbg_state  (o_dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req(input logic [3:0] v);
    @(negedge clk);
    i_req = v;
    @(negedge clk);
    i_req = 4'b0000;
  endtask

  // A 1 ms tick lands 20 cycles after the previous call point.
  task automatic do_tick();
    repeat (19) @(negedge clk);
    i_tick_1ms = 1'b1;
    @(negedge clk);
    i_tick_1ms = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  initial begin
    i_res_n    = 1'b0;
    i_tick_1ms = 1'b0;
    i_req      = 4'b0000;
    cyc(3);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_add", 32'(o_dds_add_val), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'(IDLE));
    i_res_n = 1'b1;
    cyc(3);
    check("idle_hold", 32'(o_busy), 32'd0);

    // Effect 0: latency, noise-only step, exactly 3 ticks.
    pulse_req(4'b0001);
    check("e0_t1_busy", 32'(o_busy), 32'd0);
    cyc(1);
    check("e0_t2_busy", 32'(o_busy), 32'd1);
    check("e0_t2_duck", 32'(o_bgm_duck), 32'd1);
    check("e0_t2_id", 32'(o_active_id), 32'd0);
    check("e0_t2_noise", 32'(o_noise_en), 32'd0);
    cyc(1);
    check("e0_t3_noise", 32'(o_noise_en), 32'd1);
    check("e0_t3_tone", 32'(o_tone_en), 32'd0);
    ticks(2);
    check("e0_tick2_noise", 32'(o_noise_en), 32'd1);
    check("e0_tick2_busy", 32'(o_busy), 32'd1);
    do_tick();
    check("e0_end_noise", 32'(o_noise_en), 32'd0);
    check("e0_end_busy", 32'(o_busy), 32'd0);
    check("e0_end_duck", 32'(o_bgm_duck), 32'd0);
    check("e0_end_state", 32'(o_dbg_state), 32'(IDLE));

    // Effect 2: three tone steps of 2, 2 and 4 ticks.
    exp_q.push_back(16'h0F00);
    exp_q.push_back(16'h1400);
    exp_q.push_back(16'h1E00);
    pulse_req(4'b0100);
    cyc(1);
    check("e2_id", 32'(o_active_id), 32'd2);
    cyc(1);
    exp_add = exp_q.pop_front();
    check("e2_s0_add", 32'(o_dds_add_val), 32'(exp_add));
    check("e2_s0_tone", 32'(o_tone_en), 32'd1);
    do_tick();
    check("e2_s0_hold", 32'(o_dds_add_val), 32'(exp_add));
    do_tick();
    check("e2_s0_fetch", 32'(o_dbg_state), 32'(FETCH));
    cyc(1);
    exp_add = exp_q.pop_front();
    check("e2_s1_add", 32'(o_dds_add_val), 32'(exp_add));
    ticks(2);
    cyc(1);
    exp_add = exp_q.pop_front();
    check("e2_s2_add", 32'(o_dds_add_val), 32'(exp_add));
    ticks(3);
    check("e2_s2_busy", 32'(o_busy), 32'd1);
    do_tick();
    check("e2_end_tone", 32'(o_tone_en), 32'd0);
    check("e2_end_busy", 32'(o_busy), 32'd0);
    check("e2_end_add", 32'(o_dds_add_val), 32'h1E00);

    // Effect 0 preempted by effect 2; effect 0 must not resume.
    pulse_req(4'b0001);
    cyc(2);
    do_tick();
    pulse_req(4'b0100);
    cyc(1);
    check("pre_id", 32'(o_active_id), 32'd2);
    check("pre_keep_noise", 32'(o_noise_en), 32'd1);
    cyc(1);
    check("pre_add", 32'(o_dds_add_val), 32'h0F00);
    check("pre_noise", 32'(o_noise_en), 32'd0);
    ticks(8);
    check("pre_end_busy", 32'(o_busy), 32'd0);
    cyc(3);
    check("pre_no_resume", 32'(o_busy), 32'd0);

    // Effect 2 playing, effect 0 waits then follows with no gap.
    pulse_req(4'b0100);
    cyc(2);
    pulse_req(4'b0001);
    cyc(2);
    check("low_ignored_id", 32'(o_active_id), 32'd2);
    check("low_ignored_add", 32'(o_dds_add_val), 32'h0F00);
    ticks(8);
    check("low_gap_busy", 32'(o_busy), 32'd0);
    cyc(1);
    check("low_next_busy", 32'(o_busy), 32'd1);
    check("low_next_id", 32'(o_active_id), 32'd0);
    cyc(1);
    check("low_next_noise", 32'(o_noise_en), 32'd1);
    ticks(3);
    check("low_done", 32'(o_busy), 32'd0);

    // Simultaneous 0 and 2, then restart of 2 mid-play.
    pulse_req(4'b0101);
    cyc(1);
    check("sim_id", 32'(o_active_id), 32'd2);
    cyc(1);
    ticks(2);
    cyc(1);
    check("sim_s1_add", 32'(o_dds_add_val), 32'h1400);
    pulse_req(4'b0100);
    cyc(1);
    check("rst2_state", 32'(o_dbg_state), 32'(FETCH));
    check("rst2_keep_add", 32'(o_dds_add_val), 32'h1400);
    cyc(1);
    check("rst2_add", 32'(o_dds_add_val), 32'h0F00);
    ticks(8);
    cyc(1);
    check("sim_then0_id", 32'(o_active_id), 32'd0);
    check("sim_then0_busy", 32'(o_busy), 32'd1);
    cyc(1);
    ticks(3);
    check("sim_done", 32'(o_busy), 32'd0);

    // Effect 3 has no last flag: stops after slot 7, never wraps.
    pulse_req(4'b1000);
    cyc(2);
    check("e3_s0_add", 32'(o_dds_add_val), 32'h0800);
    ticks(7);
    cyc(1);
    check("e3_s7_add", 32'(o_dds_add_val), 32'h0F00);
    check("e3_s7_busy", 32'(o_busy), 32'd1);
    do_tick();
    check("e3_end_busy", 32'(o_busy), 32'd0);
    check("e3_end_state", 32'(o_dbg_state), 32'(IDLE));
    cyc(3);
    check("e3_no_wrap", 32'(o_busy), 32'd0);

    // Asynchronous reset mid-play with a request pending.
    pulse_req(4'b0100);
    cyc(2);
    do_tick();
    pulse_req(4'b0001);
    #2;
    i_res_n = 1'b0;
    #1;
    check("ar_busy", 32'(o_busy), 32'd0);
    check("ar_tone", 32'(o_tone_en), 32'd0);
    check("ar_add", 32'(o_dds_add_val), 32'd0);
    check("ar_id", 32'(o_active_id), 32'd0);
    check("ar_duck", 32'(o_bgm_duck), 32'd0);
    cyc(2);
    i_res_n = 1'b1;
    cyc(6);
    check("ar_post_busy", 32'(o_busy), 32'd0);
    check("ar_post_state", 32'(o_dbg_state), 32'(IDLE));
    check("ar_post_noise", 32'(o_noise_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
